// File: rtl/fizzbuzz_pkg.sv
// Shared types and constants for the FizzBuzz ASCII formatter.
package fizzbuzz_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, CONV, TEXT, DIGIT, TERM} fb_state_e;

  localparam logic [7:0] ASCII_F  = 8'h46;
  localparam logic [7:0] ASCII_I  = 8'h69;
  localparam logic [7:0] ASCII_Z  = 8'h7A;
  localparam logic [7:0] ASCII_B  = 8'h42;
  localparam logic [7:0] ASCII_U  = 8'h75;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Widest number an entry can carry; the top only uses the low W bits.
  localparam int FB_NUM_W_MAX = 16;
  // Wide enough for "FizzBuzz" and any digit string of FB_NUM_W_MAX bits.
  localparam int FB_IDX_W     = 5;

  typedef struct packed {
    logic                    is_fizz;
    logic                    is_buzz;
    logic [FB_NUM_W_MAX-1:0] number;
  } fb_entry_t;

  // Decimal digits needed for 2^w-1.
  function automatic int fb_num_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/fizzbuzz_sync_fifo.sv
// Synchronous FIFO with combinational head read and extra-bit wrap pointers.
module fizzbuzz_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  assign o_empty = (wr_q == rd_q);
  assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign o_data  = mem_q[rd_q[AW-1:0]];
  assign wr_en   = i_push && !o_full;
  assign rd_en   = i_pop && !o_empty;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (wr_en) wr_d = wr_q + (AW+1)'(1);
    if (rd_en) rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en && !i_rst) mem_q[wr_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/fizzbuzz_ascii_fmt.sv
// FizzBuzz item formatter: FIFO-buffered items out as ASCII lines.
// Define FIZZBUZZ_FMT_CRLF_EN for "\r\n" line endings instead of "\n".
module fizzbuzz_ascii_fmt
  import fizzbuzz_pkg::*;
#(
  parameter int  G_LENGTH     = 100,
  parameter int  G_FIFO_DEPTH = 8,
  localparam int W            = $clog2(G_LENGTH)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic         i_is_fizz,
  input  logic         i_is_buzz,
  input  logic [W-1:0] i_number,
  output logic [7:0]   o_char,
  output logic         o_char_valid,
  input  logic         i_char_ready,
  output logic         o_overflow,
  output logic         o_busy
);
  localparam int ND = fb_num_digits(W);
`ifdef FIZZBUZZ_FMT_CRLF_EN
  localparam logic [7:0] TERM_FIRST = ASCII_CR;
`else
  localparam logic [7:0] TERM_FIRST = ASCII_LF;
`endif

  fb_state_e              state_q, state_d;
  fb_entry_t              item_q, item_d;
  logic [ND-1:0][3:0]     bcd_q, bcd_d;
  logic [W-1:0]           shreg_q, shreg_d;
  logic [FB_IDX_W-1:0]    cnt_q, cnt_d;
  logic [7:0]             char_q, char_d;
  logic                   vld_q, vld_d;
  logic                   ovf_q, ovf_d;

  fb_entry_t              wr_entry, rd_entry;
  logic                   fifo_full, fifo_empty, push, pop, fire;
  logic [ND-1:0][3:0]     bcd_adj, bcd_shift;
  logic [4*ND:0]          bcd_cat;
  logic [FB_IDX_W-1:0]    num_len, cur_len, dsel;
  logic [3:0]             digit;
  logic [7:0]             text_char, cur_char;
  logic                   buzz_word;
  logic                   unused_num_hi;

  assign wr_entry = '{is_fizz: i_is_fizz, is_buzz: i_is_buzz,
                      number: FB_NUM_W_MAX'(i_number)};
  assign push     = i_valid && !fifo_full;

  fizzbuzz_sync_fifo #(
    .WIDTH ($bits(fb_entry_t)),
    .DEPTH (G_FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (wr_entry),
    .i_pop   (pop),
    .o_data  (rd_entry),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign unused_num_hi = |(item_q.number >> W);

  // One double-dabble step: add 3 to digits >= 5, then shift in the next MSB.
  always_comb begin
    for (int i = 0; i < ND; i++)
      bcd_adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
    bcd_cat   = {bcd_adj, shreg_q[W-1]};
    bcd_shift = bcd_cat[4*ND-1:0];
  end

  always_comb begin
    num_len = FB_IDX_W'(1);
    for (int i = 1; i < ND; i++)
      if (bcd_q[i] != 4'd0) num_len = FB_IDX_W'(i + 1);
    dsel  = num_len - cnt_q - FB_IDX_W'(1);
    digit = 4'd0;
    for (int i = 0; i < ND; i++)
      if (dsel == FB_IDX_W'(i)) digit = bcd_q[i];
  end

  // "Buzz" letters for buzz-only items and the second half of "FizzBuzz".
  always_comb begin
    buzz_word = item_q.is_buzz && (!item_q.is_fizz || cnt_q[2]);
    case (cnt_q[1:0])
      2'd0:    text_char = buzz_word ? ASCII_B : ASCII_F;
      2'd1:    text_char = buzz_word ? ASCII_U : ASCII_I;
      default: text_char = ASCII_Z;
    endcase
  end

  assign cur_len  = (state_q == TEXT) ?
                    ((item_q.is_fizz && item_q.is_buzz) ? FB_IDX_W'(8) : FB_IDX_W'(4)) :
                    num_len;
  assign cur_char = (state_q == TEXT) ? text_char : (ASCII_0 + {4'h0, digit});
  assign fire     = !vld_q || i_char_ready;

  always_comb begin
    state_d = state_q;
    item_d  = item_q;
    bcd_d   = bcd_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    vld_d   = vld_q;
    ovf_d   = ovf_q || (i_valid && fifo_full);
    pop     = 1'b0;
    unique case (state_q)
      IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        item_d  = rd_entry;
        state_d = LOAD;
      end
      LOAD: begin
        bcd_d   = '0;
        shreg_d = item_q.number[W-1:0];
        cnt_d   = '0;
        state_d = (item_q.is_fizz || item_q.is_buzz) ? TEXT : CONV;
      end
      CONV: begin
        bcd_d   = bcd_shift;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + FB_IDX_W'(1);
        if (cnt_q == FB_IDX_W'(W - 1)) begin
          cnt_d   = '0;
          state_d = DIGIT;
        end
      end
      // Output register refills on the edge that drains it, so no bubbles.
      TEXT, DIGIT: if (fire) begin
        vld_d = 1'b1;
        if (cnt_q < cur_len) begin
          char_d = cur_char;
          cnt_d  = cnt_q + FB_IDX_W'(1);
        end else begin
          char_d  = TERM_FIRST;
          cnt_d   = '0;
          state_d = TERM;
        end
      end
      TERM: if (i_char_ready) begin
`ifdef FIZZBUZZ_FMT_CRLF_EN
        if (cnt_q == '0) begin
          char_d = ASCII_LF;
          cnt_d  = FB_IDX_W'(1);
        end else begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
`else
        vld_d   = 1'b0;
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      item_q  <= '0;
      bcd_q   <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      char_q  <= 8'h00;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      item_q  <= item_d;
      bcd_q   <= bcd_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_char       = char_q;
  assign o_char_valid = vld_q;
  assign o_overflow   = ovf_q;
  assign o_busy       = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_fizzbuzz_ascii_fmt.sv
// Self-checking bench for fizzbuzz_ascii_fmt against a string-level reference.
module tb_fizzbuzz_ascii_fmt;
  import fizzbuzz_pkg::*;

  localparam int LEN   = 100;
  localparam int DEPTH = 8;
  localparam int W     = $clog2(LEN);

  logic         clk = 1'b0;
  logic         rst, vld, fz, bz, rdy;
  logic [W-1:0] num;
  logic [7:0]   o_char;
  logic         o_char_valid, o_overflow, o_busy;

  always #5 clk = ~clk;

  fizzbuzz_ascii_fmt #(.G_LENGTH(LEN), .G_FIFO_DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (vld),
    .i_is_fizz    (fz),
    .i_is_buzz    (bz),
    .i_number     (num),
    .o_char       (o_char),
    .o_char_valid (o_char_valid),
    .i_char_ready (rdy),
    .o_overflow   (o_overflow),
    .o_busy       (o_busy)
  );

  int  n_chk = 0;
  int  n_fail = 0;
  byte got_q[$];
  byte exp_q[$];
  bit  rnd_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) rdy = ($urandom_range(3) != 0);
  endtask

  function automatic string ref_line(input bit f, input bit b, input int n);
    string s;
    if (f && b)  s = "FizzBuzz";
    else if (f)  s = "Fizz";
    else if (b)  s = "Buzz";
    else         s = $sformatf("%0d", n);
`ifdef FIZZBUZZ_FMT_CRLF_EN
    s = {s, "\r\n"};
`else
    s = {s, "\n"};
`endif
    return s;
  endfunction

  task automatic expect_item(input bit f, input bit b, input int n);
    string s;
    s = ref_line(f, b, n);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_item(input bit f, input bit b, input int n, input bit accepted);
    vld = 1'b1; fz = f; bz = b; num = W'(n);
    tick();
    vld = 1'b0;
    if (accepted) expect_item(f, b, n);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      if (!o_busy && !o_char_valid) break;
      tick();
    end
    chk("idle", {30'd0, o_busy, o_char_valid}, 32'd0);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  // Edges from the push edge to first o_char_valid: one to pop, then the latency.
  task automatic measure(input string tag, input bit f, input bit b, input int n, input int exp_lat);
    int lat;
    string s;
    s = ref_line(f, b, n);
    push_item(f, b, n, 1'b1);
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      if (o_char_valid) break;
      @(posedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_c0"}, o_char, {24'd0, s[0]});
    for (int k = 0; k < 20; k++) begin
      if (o_char_valid && o_char == ASCII_LF) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk({tag, "_busy_fall"}, {o_busy, o_char_valid}, 2'b00);
    wait_idle();
    cmp_stream(tag);
  endtask

  // Transfer monitor plus hold-while-stalled check.
  logic       pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [7:0] pc = 8'h00;
  always @(negedge clk) begin
    if (!rst && !prst && pv && !pr)
      chk("hold", {o_char_valid, o_char}, {1'b1, pc});
    if (!rst && o_char_valid && rdy) got_q.push_back(o_char);
    pv = o_char_valid; pr = rdy; prst = rst; pc = o_char;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, nb;
    bit f, b;
    // Reset with a coincident valid pulse, which must be discarded.
    rst = 1'b1; vld = 1'b1; fz = 1'b1; bz = 1'b0; num = W'(3); rdy = 1'b1;
    tick(); tick();
    rst = 1'b0; vld = 1'b0;
    chk("rst_valid", o_char_valid, 1'b0);
    chk("rst_char", o_char, 8'h00);
    chk("rst_ovf", o_overflow, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    repeat (4) tick();
    chk("discard_busy", o_busy, 1'b0);
    chk("discard_out", got_q.size(), 0);

    measure("num7", 1'b0, 1'b0, 7, 3 + W);
    measure("fizz3", 1'b1, 1'b0, 3, 3);

    push_item(1'b1, 1'b1, 15, 1'b1);
    push_item(1'b0, 1'b0, 0, 1'b1);
    push_item(1'b0, 1'b0, 99, 1'b1);
    push_item(1'b0, 1'b0, 100, 1'b1);
    push_item(1'b0, 1'b1, 5, 1'b1);
    push_item(1'b1, 1'b0, 9, 1'b1);
    wait_idle();
    cmp_stream("dir");

    // Stall on the first character of "Buzz".
    rdy = 1'b0;
    push_item(1'b0, 1'b1, 10, 1'b1);
    for (int k = 0; k < 20 && !o_char_valid; k++) tick();
    chk("bp_first", {o_char_valid, o_char}, {1'b1, ASCII_B});
    repeat (5) begin
      tick();
      chk("bp_hold", {o_char_valid, o_char}, {1'b1, ASCII_B});
    end
    rdy = 1'b1;
    wait_idle();
    cmp_stream("bp");

    // A primer item occupies the formatter, so the FIFO alone sees the nine.
    rdy = 1'b0;
    push_item(1'b0, 1'b0, 1, 1'b1);
    repeat (3) tick();
    for (int k = 0; k < 9; k++) begin
      n = 20 + k;
      vld = 1'b1; fz = (n % 3 == 0); bz = (n % 5 == 0); num = W'(n);
      tick();
      if (k < 8) expect_item(n % 3 == 0, n % 5 == 0, n);
      if (k == 7) chk("ovf_pre", o_overflow, 1'b0);
    end
    vld = 1'b0;
    chk("ovf_set", o_overflow, 1'b1);
    chk("ovf_busy", o_busy, 1'b1);
    rdy = 1'b1;
    wait_idle();
    chk("ovf_sticky", o_overflow, 1'b1);
    cmp_stream("ovf");

    // Reset while 'i' of "Fizz" is presented: only 'F' reaches the sink.
    push_item(1'b1, 1'b0, 3, 1'b0);
    exp_q.push_back(8'(ASCII_F));
    for (int k = 0; k < 40; k++) begin
      if (o_char_valid && o_char == ASCII_I) break;
      tick();
    end
    chk("rst_mid_at_i", o_char, ASCII_I);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", o_char_valid, 1'b0);
    chk("rst_mid_ovf", o_overflow, 1'b0);
    chk("rst_mid_busy", o_busy, 1'b0);
    repeat (3) tick();
    cmp_stream("rst_mid");
    push_item(1'b0, 1'b0, 42, 1'b1);
    wait_idle();
    cmp_stream("post_rst");

    // Random bursts that fit the FIFO, with random sink backpressure.
    rnd_rdy = 1'b1;
    for (int bi = 0; bi < 10; bi++) begin
      nb = $urandom_range(1, DEPTH);
      for (int k = 0; k < nb; k++) begin
        n = $urandom_range(0, LEN - 1);
        if ($urandom_range(7) == 0) begin
          f = 1'($urandom_range(1)); b = 1'($urandom_range(1));
        end else begin
          f = (n % 3 == 0); b = (n % 5 == 0);
        end
        push_item(f, b, n, 1'b1);
        repeat ($urandom_range(0, 3)) tick();
      end
      wait_idle();
      cmp_stream("rnd");
    end
    rnd_rdy = 1'b0;
    rdy = 1'b1;
    chk("rnd_ovf", o_overflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
